// File: rtl/fwd_pkg.sv
// Purpose:      shared types and default constants for the decode forwarding unit.
// Latency:      n/a (types and constants only).
// Backpressure: n/a.
// Contents: fwdTag_t producer tag {vld, regIdx, isLoad}; default parameter values.
package fwd_pkg;

   // Default configuration of decode_fwd_unit.
   localparam int FWD_DATA_W     = 16;
   localparam int FWD_NUM_REGS   = 8;
   localparam int FWD_NUM_RD     = 2;
   localparam int FWD_DEPTH      = 3;
   localparam int FWD_LOAD_STAGE = 2;

   // Register index field is sized for the largest supported register file
   // (256 entries); narrower indices are zero-extended into it.
   localparam int FWD_MAX_REG_W  = 8;

   // One in-flight producer: entry k of the tag pipeline describes the
   // instruction currently sitting in stage k after decode.
   typedef struct packed {
      logic                     vld;
      logic [FWD_MAX_REG_W-1:0] regIdx;
      logic                     isLoad;
   } fwdTag_t;

endpackage : fwd_pkg

// File: rtl/fwd_port_sel.sv
// Purpose:      youngest-match forwarding select for one decode read port.
// Latency:      combinational, zero cycles.
// Backpressure: none; raises needStall when the youngest match is a load not yet ready.
// Ports: rdReq/rdReg request, tags from the tag pipeline, stageData result buses,
//        rfData register-file value, rdData forwarded operand, needStall.
module fwd_port_sel
   import fwd_pkg::*;
#(
   parameter int DATA_W     = FWD_DATA_W,
   parameter int DEPTH      = FWD_DEPTH,
   parameter int LOAD_STAGE = FWD_LOAD_STAGE
) (
   input  logic                     rdReq,
   input  logic [FWD_MAX_REG_W-1:0] rdReg,
   input  fwdTag_t [DEPTH-1:0]      tags,
   input  logic [DEPTH*DATA_W-1:0]  stageData,
   input  logic [DATA_W-1:0]        rfData,
   output logic [DATA_W-1:0]        rdData,
   output logic                     needStall
);

   // Scan oldest to youngest so the last hit (lowest k) wins. Both outputs
   // are rewritten on every hit, so an older ready producer can never mask
   // a younger one whose load data is not available yet.
   always_comb begin
      rdData    = rfData;
      needStall = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (rdReq && tags[k].vld && (tags[k].regIdx == rdReg)) begin
            if (!tags[k].isLoad || (k >= LOAD_STAGE)) begin
               rdData    = stageData[k*DATA_W +: DATA_W];
               needStall = 1'b0;
            end else begin
               rdData    = rfData;
               needStall = 1'b1;
            end
         end
      end
   end

endmodule : fwd_port_sel

// File: rtl/decode_fwd_unit.sv
// Purpose:      operand forwarding and load-use stall detection at decode.
// Latency:      rdData/stall combinational (zero cycles); tag pipeline advances one stage per cycle.
// Backpressure: hold freezes the tag pipeline; stall inserts a bubble instead of the issuing instruction.
// Ports: clk, rst_n (async active-low); issue_* describe the instruction leaving decode;
//        rd_req/rd_reg/rf_data per read port; stage_data per tracked stage;
//        rd_data forwarded operands; stall; stall_cnt (only with FWD_STALL_CNT_EN).
// Optional feature: define FWD_STALL_CNT_EN to add the saturating stall_cnt counter.
module decode_fwd_unit
   import fwd_pkg::*;
#(
   parameter int DATA_W       = FWD_DATA_W,
   parameter int NUM_REGS     = FWD_NUM_REGS,
   parameter int NUM_RD       = FWD_NUM_RD,
   parameter int DEPTH        = FWD_DEPTH,
   parameter int LOAD_STAGE   = FWD_LOAD_STAGE,
   localparam int REG_W       = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_valid,
   input  logic                     issue_wr_en,
   input  logic [REG_W-1:0]         issue_wr_reg,
   input  logic                     issue_is_load,
   input  logic                     hold,
   input  logic [NUM_RD-1:0]        rd_req,
   input  logic [NUM_RD*REG_W-1:0]  rd_reg,
   input  logic [NUM_RD*DATA_W-1:0] rf_data,
   input  logic [DEPTH*DATA_W-1:0]  stage_data,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     stall
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [15:0]              stall_cnt
`endif
);

   fwdTag_t [DEPTH-1:0] tagQ;
   fwdTag_t             newTag;
   logic [NUM_RD-1:0]   portStall;

   // A stalled decode instruction must not enter the pipeline; a bubble
   // takes its place so the blocking load keeps moving toward LOAD_STAGE.
   always_comb begin
      newTag        = '0;
      newTag.vld    = issue_valid & issue_wr_en & ~stall;
      newTag.regIdx = FWD_MAX_REG_W'(issue_wr_reg);
      newTag.isLoad = issue_is_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tagQ <= '0;
      end else if (!hold) begin
         tagQ[0] <= newTag;
         for (int k = 1; k < DEPTH; k++) begin
            tagQ[k] <= tagQ[k-1];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : gPort
      logic [FWD_MAX_REG_W-1:0] rdRegExt;
      assign rdRegExt = FWD_MAX_REG_W'(rd_reg[p*REG_W +: REG_W]);

      fwd_port_sel #(
         .DATA_W     (DATA_W),
         .DEPTH      (DEPTH),
         .LOAD_STAGE (LOAD_STAGE)
      ) uSel (
         .rdReq     (rd_req[p]),
         .rdReg     (rdRegExt),
         .tags      (tagQ),
         .stageData (stage_data),
         .rfData    (rf_data[p*DATA_W +: DATA_W]),
         .rdData    (rd_data[p*DATA_W +: DATA_W]),
         .needStall (portStall[p])
      );
   end

   assign stall = |portStall;

`ifdef FWD_STALL_CNT_EN
   logic [15:0] stallCntQ;

   // Counts only cycles in which the stall actually costs an issue slot;
   // held cycles are charged to the downstream stall instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCntQ <= '0;
      end else if (stall && !hold && (stallCntQ != 16'hFFFF)) begin
         stallCntQ <= stallCntQ + 16'd1;
      end
   end

   assign stall_cnt = stallCntQ;
`endif

endmodule : decode_fwd_unit

// File: tb/tb_decode_fwd_unit.sv
// Purpose:      directed self-checking bench for decode_fwd_unit (default parameters).
// Latency:      n/a.
// Backpressure: n/a.
module tb_decode_fwd_unit;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_wr_en;
   logic [2:0]  issue_wr_reg;
   logic        issue_is_load;
   logic        hold;
   logic [1:0]  rd_req;
   logic [5:0]  rd_reg;
   logic [31:0] rf_data;
   logic [47:0] stage_data;
   logic [31:0] rd_data;
   logic        stall;
`ifdef FWD_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int nChecks;
   int nErrors;

   decode_fwd_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .issue_wr_en   (issue_wr_en),
      .issue_wr_reg  (issue_wr_reg),
      .issue_is_load (issue_is_load),
      .hold          (hold),
      .rd_req        (rd_req),
      .rd_reg        (rd_reg),
      .rf_data       (rf_data),
      .stage_data    (stage_data),
      .rd_data       (rd_data),
      .stall         (stall)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic doIssue(input logic v, input logic [2:0] r, input logic ld);
      issue_valid   = v;
      issue_wr_en   = v;
      issue_wr_reg  = r;
      issue_is_load = ld;
   endtask

   task automatic setRead(input logic [1:0] req, input logic [2:0] r0, input logic [2:0] r1);
      rd_req = req;
      rd_reg = {r1, r0};
   endtask

   task automatic flush;
      rd_req = 2'b00;
      doIssue(1'b0, 3'd0, 1'b0);
      repeat (3) tick();
   endtask

   initial begin
      nChecks = 0;
      nErrors = 0;
      rst_n   = 1'b0;
      hold    = 1'b0;
      doIssue(1'b0, 3'd0, 1'b0);
      rf_data    = {16'h2222, 16'h1111};
      stage_data = {16'hC2C2, 16'hB1B1, 16'h1234};
      setRead(2'b11, 3'd0, 3'd1);
      #3;
      // Reset state: no stall, register-file data passes straight through.
      checkEq("rst_stall", {31'd0, stall}, 32'd0);
      checkEq("rst_rd0", {16'd0, rd_data[15:0]}, 32'h1111);
      checkEq("rst_rd1", {16'd0, rd_data[31:16]}, 32'h2222);
`ifdef FWD_STALL_CNT_EN
      checkEq("rst_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      rd_req = 2'b00;

      // ALU producer R3 forwarded from each stage as it ages, then dropped.
      doIssue(1'b1, 3'd3, 1'b0);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b01, 3'd3, 3'd0);
      settle();
      checkEq("alu_k0_rd0", {16'd0, rd_data[15:0]}, 32'h1234);
      checkEq("alu_k0_stall", {31'd0, stall}, 32'd0);
      checkEq("alu_k0_rd1_idle", {16'd0, rd_data[31:16]}, 32'h2222);
      tick();
      checkEq("alu_k1_rd0", {16'd0, rd_data[15:0]}, 32'hB1B1);
      tick();
      checkEq("alu_k2_rd0", {16'd0, rd_data[15:0]}, 32'hC2C2);
      tick();
      checkEq("alu_gone_rd0", {16'd0, rd_data[15:0]}, 32'h1111);

      // Register 0 forwards like any other register.
      flush();
      doIssue(1'b1, 3'd0, 1'b0);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b10, 3'd0, 3'd0);
      settle();
      checkEq("r0_rd1", {16'd0, rd_data[31:16]}, 32'h1234);
      checkEq("r0_rd0_idle", {16'd0, rd_data[15:0]}, 32'h1111);

      // Load-use: LD R5 then a dependent read; the stalled ADD R6 must not issue.
      flush();
      doIssue(1'b1, 3'd5, 1'b1);
      tick();
      doIssue(1'b1, 3'd6, 1'b0);
      setRead(2'b11, 3'd5, 3'd6);
      settle();
      checkEq("ld_c1_stall", {31'd0, stall}, 32'd1);
      checkEq("ld_c1_rd0", {16'd0, rd_data[15:0]}, 32'h1111);
      tick();
      checkEq("ld_c2_stall", {31'd0, stall}, 32'd1);
      checkEq("ld_c2_bubble_rd1", {16'd0, rd_data[31:16]}, 32'h2222);
      tick();
      checkEq("ld_c3_stall", {31'd0, stall}, 32'd0);
      checkEq("ld_c3_rd0", {16'd0, rd_data[15:0]}, 32'hC2C2);
`ifdef FWD_STALL_CNT_EN
      checkEq("ld_cnt", {16'd0, stall_cnt}, 32'd2);
`endif
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      settle();
      checkEq("ld_after_rd1", {16'd0, rd_data[31:16]}, 32'h1234);
      checkEq("ld_after_rd0", {16'd0, rd_data[15:0]}, 32'h1111);

      // R2 produced at k=2 and k=0: both ports take the younger value.
      flush();
      stage_data = {16'hAAAA, 16'hB1B1, 16'hBBBB};
      doIssue(1'b1, 3'd2, 1'b0);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      tick();
      doIssue(1'b1, 3'd2, 1'b0);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b11, 3'd2, 3'd2);
      settle();
      checkEq("young_rd0", {16'd0, rd_data[15:0]}, 32'hBBBB);
      checkEq("young_rd1", {16'd0, rd_data[31:16]}, 32'hBBBB);

      // LD R4 older, ADD R4 younger: forward the ALU result, no stall.
      flush();
      stage_data = {16'hC2C2, 16'hB1B1, 16'h1234};
      doIssue(1'b1, 3'd4, 1'b1);
      tick();
      doIssue(1'b1, 3'd4, 1'b0);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b01, 3'd4, 3'd0);
      settle();
      checkEq("ldadd_stall", {31'd0, stall}, 32'd0);
      checkEq("ldadd_rd0", {16'd0, rd_data[15:0]}, 32'h1234);

      // Reversed: younger load must stall despite the older ready ADD.
      flush();
      doIssue(1'b1, 3'd4, 1'b0);
      tick();
      doIssue(1'b1, 3'd4, 1'b1);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b01, 3'd4, 3'd0);
      settle();
      checkEq("addld_stall", {31'd0, stall}, 32'd1);
      checkEq("addld_rd0", {16'd0, rd_data[15:0]}, 32'h1111);
      rd_req = 2'b00;

      // hold freezes the load at k=0 and ignores the issue inputs.
      flush();
      doIssue(1'b1, 3'd1, 1'b1);
      tick();
      doIssue(1'b1, 3'd7, 1'b0);
      setRead(2'b11, 3'd1, 3'd7);
      hold = 1'b1;
      settle();
      checkEq("hold_c0_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkEq($sformatf("hold_c%0d_stall", i + 1), {31'd0, stall}, 32'd1);
         checkEq($sformatf("hold_c%0d_rd1", i + 1), {16'd0, rd_data[31:16]}, 32'h2222);
      end
`ifdef FWD_STALL_CNT_EN
      checkEq("hold_cnt", {16'd0, stall_cnt}, 32'd2);
`endif
      hold = 1'b0;
      doIssue(1'b0, 3'd0, 1'b0);
      tick();
      checkEq("unhold_k1_stall", {31'd0, stall}, 32'd1);
      tick();
      checkEq("unhold_k2_stall", {31'd0, stall}, 32'd0);
      checkEq("unhold_k2_rd0", {16'd0, rd_data[15:0]}, 32'hC2C2);
`ifdef FWD_STALL_CNT_EN
      checkEq("unhold_cnt", {16'd0, stall_cnt}, 32'd4);
`endif

      // Asynchronous reset in the middle of a load-use stall.
      flush();
      doIssue(1'b1, 3'd5, 1'b1);
      tick();
      doIssue(1'b0, 3'd0, 1'b0);
      setRead(2'b01, 3'd5, 3'd0);
      tick();
      checkEq("mid_pre_stall", {31'd0, stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkEq("mid_rst_stall", {31'd0, stall}, 32'd0);
      checkEq("mid_rst_rd0", {16'd0, rd_data[15:0]}, 32'h1111);
`ifdef FWD_STALL_CNT_EN
      checkEq("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      tick();
      rst_n = 1'b1;
      settle();
      checkEq("post_rst_stall", {31'd0, stall}, 32'd0);
      tick();
      checkEq("post_rst_rd0", {16'd0, rd_data[15:0]}, 32'h1111);
      checkEq("post_rst_stall2", {31'd0, stall}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule : tb_decode_fwd_unit

// File: doc/decode_fwd_unit.md
DECODE_FWD_UNIT -- requirements
Module: decode_fwd_unit

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Parameter NUM_REGS, default 8: architectural register count; REG_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2: decode read ports (Rs, Rt).
REQ-004 Parameter DEPTH, default 3: tracked producer stages after decode (0=X, 1=M, 2=WB).
REQ-005 Parameter LOAD_STAGE, default 2: first stage index at which load data is valid.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 issue_valid  input  1  decode instruction leaves decode this cycle.
REQ-009 issue_wr_en  input  1  issuing instruction writes a register.
REQ-010 issue_wr_reg  input  REG_W  destination register of issuing instruction.
REQ-011 issue_is_load  input  1  issuing instruction is a memory read.
REQ-012 hold  input  1  downstream stall; freezes the tracked tag pipeline.
REQ-013 rd_req  input  NUM_RD  per-port "operand needed in decode".
REQ-014 rd_reg  input  NUM_RD*REG_W  per-port source register.
REQ-015 rf_data  input  NUM_RD*DATA_W  per-port register-file read data.
REQ-016 stage_data  input  DEPTH*DATA_W  result bus of each tracked stage, slot k at bits [k*DATA_W +: DATA_W].
REQ-017 rd_data  output  NUM_RD*DATA_W  per-port forwarded operand.
REQ-018 stall  output  1  decode must stall this cycle.
REQ-019 stall_cnt  output  16  saturating stall-cycle count (present only with FWD_STALL_CNT_EN).

Function
REQ-020 Internal tag pipeline: DEPTH entries {vld, reg, is_load}; entry k describes the instruction currently in stage k.
REQ-021 When hold=0, entries shift k->k+1 each cycle; entry DEPTH-1 is discarded; entry 0 loads {issue_valid & issue_wr_en & ~stall, issue_wr_reg, issue_is_load}.
REQ-022 When stall=1 and hold=0, entry 0 loads a bubble (vld=0) regardless of issue_valid.
REQ-023 When hold=1, all entries keep their value; issue inputs are ignored.
REQ-024 Per port p: match[k] = rd_req[p] & vld[k] & (reg[k] == rd_reg[p]); only the lowest matching k (youngest producer) is considered.
REQ-025 Port p forwards stage_data[k] for the youngest match k if ~is_load[k] or k >= LOAD_STAGE; otherwise rd_data[p] = rf_data[p].
REQ-026 With no match, rd_data[p] = rf_data[p]; rd_data is combinational from current inputs and registered tags (zero added latency).
REQ-027 stall = OR over ports of (youngest match is_load and k < LOAD_STAGE); an older ready match never suppresses a younger unready one.
REQ-028 Register 0 is an ordinary register; no hardwired-zero exemption.
REQ-029 Two ports matching the same producer forward the same data independently.
REQ-030 A load-use stall resolves automatically: bubbles advance the load until k = LOAD_STAGE, then forwarding proceeds.

Reset
REQ-031 rst_n low asynchronously clears all vld bits; reg/is_load fields cleared to 0.
REQ-032 During and after reset, stall = 0 and rd_data = rf_data until new producers issue.
REQ-033 Reset mid-stall drops all in-flight tags; stall deasserts immediately.
REQ-034 stall_cnt resets to 0.

Configuration
REQ-035 Macro FWD_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle with stall=1 and hold=0, saturates at 16'hFFFF.
REQ-036 Macro FWD_STALL_CNT_EN undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-037 Shared package fwd_pkg holds the tag struct typedef (vld, reg, is_load) and default parameter constants.
REQ-038 One sub-module fwd_port_sel (youngest-match priority select, per port) instantiated NUM_RD times via generate.

Verification
REQ-039 Issue ADD wr R3; next cycle rd_req[0]=1, rd_reg=R3, stage_data[0]=16'h1234 -> rd_data[0]=16'h1234, stall=0.
REQ-040 Issue LD wr R5; next cycle read R5 -> stall=1 for 2 cycles (load at k=0,1), third cycle rd_data=stage_data[2], stall=0.
REQ-041 R2 written at k=2 (data 16'hAAAA) and k=0 (data 16'hBBBB), read R2 on both ports -> both ports 16'hBBBB.
REQ-042 LD R4 at k=1, ADD R4 at k=0, read R4 -> no stall, forward stage_data[0]; reversed order -> stall=1.
REQ-043 hold=1 for 3 cycles with LD R1 at k=0 -> stall stays 1, tags frozen, stall_cnt unchanged; hold=0 resumes.
REQ-044 Assert rst_n=0 mid load-use stall -> stall=0 asynchronously, all tags invalid, stall_cnt=0.
